// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop sync, mid-bit sampling, one word per frame with parity/frame flags.
// Latency: rx_valid one cycle after the last stop sample; no backpressure, rx_valid is a one-cycle strobe.
module uart_rx_param #(
  parameter int CLK_PER_BIT = 434,
  parameter int DATA_W      = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_uart,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        led
);

  localparam int H     = CLK_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t             state;
  logic               sync1, sync2, rx_d;
  logic               rx_s;
  logic               fall;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic               stop_cnt;
  logic [DATA_W-1:0]  shreg;
  logic               par_bit;
  logic               ferr_acc;
  logic               bit_tick;
  logic               half_tick;
  logic               perr;
  logic               ferr_now;
  logic [7:0]         led_next;

  assign rx_s      = sync2;
  assign fall      = ~rx_s & rx_d;
  assign bit_tick  = (cnt == CNT_W'(CLK_PER_BIT - 1));
  assign half_tick = (cnt == CNT_W'(H - 1));
  assign busy      = (state != IDLE);
  assign ferr_now  = ferr_acc | ~rx_s;

  always_comb begin
    perr = 1'b0;
    if (PARITY == 1)      perr = ~(^shreg ^ par_bit);
    else if (PARITY == 2) perr = ^shreg ^ par_bit;
  end

  generate
    if (DATA_W >= 8) begin : g_led_wide
      assign led_next = shreg[7:0];
    end else begin : g_led_narrow
      assign led_next = {{(8-DATA_W){1'b0}}, shreg};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= 1'b1;
      sync2      <= 1'b1;
      rx_d       <= 1'b0;
      state      <= IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      ferr_acc   <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      led        <= '0;
    end else begin
      sync1    <= rx_uart;
      sync2    <= sync1;
      rx_d     <= rx_s;
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (half_tick) begin
            cnt     <= '0;
            bit_cnt <= '0;
            // A start bit already high again at its midpoint was a glitch
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_W-1:1]};
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state    <= (PARITY != 0) ? PAR : STOP;
              stop_cnt <= 1'b0;
              ferr_acc <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PAR: begin
          if (bit_tick) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              // Return to IDLE mid stop bit so a back-to-back start edge is caught
              state      <= IDLE;
              rx_valid   <= 1'b1;
              rx_data    <= shreg;
              parity_err <= perr;
              frame_err  <= ferr_now;
              if (!perr && !ferr_now) led <= led_next;
            end else begin
              stop_cnt <= 1'b1;
              ferr_acc <= ferr_now;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench: three receiver configurations (8N1, 7E1, 8N2) at 4 clocks per bit.
module tb_uart_rx_param;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_a = 1'b1, rx_b = 1'b1, rx_c = 1'b1;

  logic [7:0] da, dc;
  logic [6:0] db;
  logic va, vb, vc, pa, pb, pc, fa, fb, fc, ba, bb, bc;
  logic [7:0] la, lb, lc;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int na = 0, nb = 0, nc = 0;
  int va_cyc = 0;
  int t0;
  int na0;
  logic [7:0] qa[$];
  logic [6:0] db_last;
  logic pb_last;
  logic [7:0] dc_last;
  logic fc_last;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_a), .rx_data(da), .rx_valid(va),
    .parity_err(pa), .frame_err(fa), .busy(ba), .led(la));

  uart_rx_param #(.CLK_PER_BIT(4), .DATA_W(7), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_b), .rx_data(db), .rx_valid(vb),
    .parity_err(pb), .frame_err(fb), .busy(bb), .led(lb));

  uart_rx_param #(.CLK_PER_BIT(4), .DATA_W(8), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .rst_n(rst_n), .rx_uart(rx_c), .rx_data(dc), .rx_valid(vc),
    .parity_err(pc), .frame_err(fc), .busy(bc), .led(lc));

  always @(negedge clk) begin
    if (va) begin
      na++;
      qa.push_back(da);
      va_cyc = cyc;
    end
    if (vb) begin
      nb++;
      db_last = db;
      pb_last = pb;
    end
    if (vc) begin
      nc++;
      dc_last = dc;
      fc_last = fc;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int idx, input logic v);
    case (idx)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Called at a falling clock edge; each bit lasts 4 clocks, LSB of bits goes first.
  task automatic send_frame(input int idx, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(idx, bits[i]);
      repeat (4) @(negedge clk);
    end
    set_line(idx, 1'b1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_rx_data", {8'd0, da}, 16'h0);
    chk("reset_rx_valid", {15'd0, va}, 16'h0);
    chk("reset_flags", {14'd0, pa, fa}, 16'h0);
    chk("reset_busy", {15'd0, ba}, 16'h0);
    chk("reset_led", {8'd0, la}, 16'h0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // 8N1 0x31 with latency
    t0 = cyc;
    send_frame(0, {6'd0, 1'b1, 8'h31, 1'b0}, 10);
    repeat (8) @(negedge clk);
    chk("a31_count", 16'(na), 16'd1);
    chk("a31_data", {8'd0, da}, 16'h31);
    chk("a31_flags", {14'd0, pa, fa}, 16'h0);
    chk("a31_led", {8'd0, la}, 16'h31);
    chk("a31_latency", 16'(va_cyc - t0), 16'd41);

    // One-clock glitch on the start bit
    rx_a = 1'b0;
    @(negedge clk); rx_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("glitch_busy_rise", {15'd0, ba}, 16'h1);
    @(negedge clk);
    @(negedge clk);
    chk("glitch_busy_fall", {15'd0, ba}, 16'h0);
    repeat (40) @(negedge clk);
    chk("glitch_no_valid", 16'(na), 16'd1);

    // Back-to-back frames with no idle gap
    qa.delete();
    send_frame(0, {6'd0, 1'b1, 8'h00, 1'b0}, 10);
    send_frame(0, {6'd0, 1'b1, 8'hFF, 1'b0}, 10);
    send_frame(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10);
    repeat (8) @(negedge clk);
    chk("b2b_count", 16'(qa.size()), 16'd3);
    if (qa.size() == 3) begin
      chk("b2b_data0", {8'd0, qa[0]}, 16'h00);
      chk("b2b_data1", {8'd0, qa[1]}, 16'hFF);
      chk("b2b_data2", {8'd0, qa[2]}, 16'h5A);
    end
    chk("b2b_led", {8'd0, la}, 16'h5A);

    // Break: line low for 12 bit times
    rx_a = 1'b0;
    repeat (48) @(negedge clk);
    rx_a = 1'b1;
    repeat (8) @(negedge clk);
    chk("break_count", 16'(na), 16'd5);
    chk("break_data", {8'd0, da}, 16'h00);
    chk("break_frame_err", {15'd0, fa}, 16'h1);
    chk("break_led_hold", {8'd0, la}, 16'h5A);

    // 7E1: 0x55 with wrong then correct parity
    send_frame(1, {6'd0, 1'b1, 1'b1, 7'h55, 1'b0}, 10);
    repeat (8) @(negedge clk);
    chk("par_bad_count", 16'(nb), 16'd1);
    chk("par_bad_data", {9'd0, db_last}, 16'h55);
    chk("par_bad_err", {15'd0, pb_last}, 16'h1);
    chk("par_bad_led", {8'd0, lb}, 16'h00);
    send_frame(1, {6'd0, 1'b1, 1'b0, 7'h55, 1'b0}, 10);
    repeat (8) @(negedge clk);
    chk("par_good_count", 16'(nb), 16'd2);
    chk("par_good_err", {15'd0, pb_last}, 16'h0);
    chk("par_good_led", {8'd0, lb}, 16'h55);

    // 8N2: second stop bit low, then a clean 0xA5
    send_frame(2, {5'd0, 1'b0, 1'b1, 8'h12, 1'b0}, 11);
    repeat (8) @(negedge clk);
    chk("stop2_count", 16'(nc), 16'd1);
    chk("stop2_frame_err", {15'd0, fc_last}, 16'h1);
    chk("stop2_led", {8'd0, lc}, 16'h00);
    send_frame(2, {5'd0, 2'b11, 8'hA5, 1'b0}, 11);
    repeat (8) @(negedge clk);
    chk("a5_count", 16'(nc), 16'd2);
    chk("a5_frame_err", {15'd0, fc_last}, 16'h0);
    chk("a5_data", {8'd0, dc_last}, 16'hA5);
    chk("a5_led", {8'd0, lc}, 16'hA5);

    // Reset after data bit 3 of 0x3C
    na0 = na;
    send_frame(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 5);
    rst_n = 1'b0;
    rx_a = 1'b1;
    #1;
    chk("rst_rx_data", {8'd0, da}, 16'h0);
    chk("rst_flags", {14'd0, pa, fa}, 16'h0);
    chk("rst_busy", {15'd0, ba}, 16'h0);
    chk("rst_led", {8'd0, la}, 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (16) @(negedge clk);
    chk("rst_no_valid", 16'(na - na0), 16'd0);
    send_frame(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (8) @(negedge clk);
    chk("post_rst_count", 16'(na - na0), 16'd1);
    chk("post_rst_data", {8'd0, da}, 16'h3C);
    chk("post_rst_led", {8'd0, la}, 16'h3C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
